ex_stage_unit: RTL and testbench

Execute stage of the 5-stage MIPS-subset pipeline. It latches the ID/EX operands on the falling clock edge and decodes the latched instruction into an ALU operation and operand-mux selects. A 32-bit ALU then produces the result and flags for the EX/MEM latch. It also produces a combinational branch-condition flag from the incoming A operand.

---
 rtl/ex_stage_unit.sv | 125 ++++++++++++
 tb/tb_ex_stage_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ex_stage_unit.sv
// Execute stage: falling-edge ID/EX operand latch, instruction decode to ALU op,
// 32-bit ALU with zero/overflow flags, and a combinational branch-condition flag.
module ex_stage_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IRi,
    input  logic [31:0] NPCi,
    input  logic [31:0] Ai,
    input  logic [31:0] Bi,
    input  logic [31:0] Immi,
    output logic        cond,
    output logic [31:0] ALUo,
    output logic        ZFo,
    output logic        OFo,
    output logic [31:0] Bo,
    output logic [31:0] IRo
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_SLTU = 3'b111;

    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] ir_q;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        is_alur;
    logic        is_branch;
    logic [2:0]  alu_op;

    logic [31:0] alu_res;
    logic [31:0] sum;
    logic [31:0] diff;
    logic        ovf;

    assign opcode    = ir_q[31:26];
    assign funct     = ir_q[5:0];
    assign is_alur   = (opcode == 6'h00);
    assign is_branch = (opcode == 6'h04) || (opcode == 6'h05);

    // Operand selects come from the already-latched IR, one latch behind IRi.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            ir_q <= 32'h0;
            a_q  <= 32'h0;
            b_q  <= 32'h0;
        end else begin
            ir_q <= IRi;
            a_q  <= is_branch ? NPCi : Ai;
            if (is_alur)
                b_q <= Bi;
            else if (is_branch)
                b_q <= {Immi[29:0], 2'b00};
            else
                b_q <= Immi;
        end
    end

    always_comb begin
        alu_op = OP_ADD;
        if (is_alur) begin
            case (funct)
                6'h20, 6'h21: alu_op = OP_ADD;
                6'h22, 6'h23: alu_op = OP_SUB;
                6'h24:        alu_op = OP_AND;
                6'h25:        alu_op = OP_OR;
                6'h26:        alu_op = OP_XOR;
                6'h27:        alu_op = OP_NOR;
                6'h2A:        alu_op = OP_SLT;
                6'h2B:        alu_op = OP_SLTU;
                default:      alu_op = OP_ADD;
            endcase
        end else begin
            case (opcode)
                6'h08, 6'h09: alu_op = OP_ADD;
                6'h0C:        alu_op = OP_AND;
                6'h0D:        alu_op = OP_OR;
                6'h0E:        alu_op = OP_XOR;
                6'h0A:        alu_op = OP_SLT;
                6'h0B:        alu_op = OP_SLTU;
                default:      alu_op = OP_ADD;
            endcase
        end
    end

    assign sum  = a_q + b_q;
    assign diff = a_q - b_q;

    always_comb begin
        alu_res = 32'h0;
        ovf     = 1'b0;
        case (alu_op)
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_NOR:  alu_res = ~(a_q | b_q);
            OP_ADD: begin
                alu_res = sum;
                ovf     = (a_q[31] == b_q[31]) && (sum[31] != a_q[31]);
            end
            OP_SUB: begin
                alu_res = diff;
                ovf     = (a_q[31] != b_q[31]) && (diff[31] != a_q[31]);
            end
            OP_SLT:  alu_res = {31'h0, ($signed(a_q) < $signed(b_q))};
            OP_SLTU: alu_res = {31'h0, (a_q < b_q)};
            default: alu_res = 32'h0;
        endcase
    end

    assign ALUo = alu_res;
    assign ZFo  = (alu_res == 32'h0);
    assign OFo  = ovf;
    assign Bo   = b_q;
    assign IRo  = ir_q;
    assign cond = (Ai == 32'h0);

endmodule

// File: tb/tb_ex_stage_unit.sv
// Directed bench for ex_stage_unit: reset, ADD overflow, immediate, branch,
// logic/compare ops, SUB to zero/overflow, and asynchronous mid-cycle reset.
module tb_ex_stage_unit;

    logic        clk;
    logic        rst;
    logic [31:0] IRi;
    logic [31:0] NPCi;
    logic [31:0] Ai;
    logic [31:0] Bi;
    logic [31:0] Immi;
    logic        cond;
    logic [31:0] ALUo;
    logic        ZFo;
    logic        OFo;
    logic [31:0] Bo;
    logic [31:0] IRo;

    int n_cmp = 0;
    int n_err = 0;

    ex_stage_unit dut (
        .clk  (clk),
        .rst  (rst),
        .IRi  (IRi),
        .NPCi (NPCi),
        .Ai   (Ai),
        .Bi   (Bi),
        .Immi (Immi),
        .cond (cond),
        .ALUo (ALUo),
        .ZFo  (ZFo),
        .OFo  (OFo),
        .Bo   (Bo),
        .IRo  (IRo)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the falling (active) edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b0;
        IRi  = 32'hDEADBEEF;
        NPCi = 32'h12345678;
        Ai   = 32'h0;
        Bi   = 32'hCAFEF00D;
        Immi = 32'h55AA55AA;
        #12;
        chk("rst_iro",  IRo,  32'h0);
        chk("rst_bo",   Bo,   32'h0);
        chk("rst_aluo", ALUo, 32'h0);
        chk("rst_zf",   {31'h0, ZFo}, 32'h1);
        chk("rst_of",   {31'h0, OFo}, 32'h0);
        chk("rst_cond", {31'h0, cond}, 32'h1);
        rst = 1'b1;

        // R-type ADD overflow
        IRi = 32'h00221820;
        step();
        Ai = 32'h7FFFFFFF;
        Bi = 32'h00000001;
        step();
        chk("add_alu", ALUo, 32'h80000000);
        chk("add_of",  {31'h0, OFo}, 32'h1);
        chk("add_zf",  {31'h0, ZFo}, 32'h0);
        chk("add_bo",  Bo, 32'h1);
        chk("add_iro", IRo, 32'h00221820);

        // addi: B takes the immediate
        IRi = 32'h20220005;
        step();
        Ai   = 32'h5;
        Bi   = 32'h9;
        Immi = 32'hFFFFFFFF;
        step();
        chk("addi_alu", ALUo, 32'h4);
        chk("addi_of",  {31'h0, OFo}, 32'h0);
        chk("addi_bo",  Bo, 32'hFFFFFFFF);

        // beq: A takes NPC, B takes imm<<2
        IRi = 32'h10200003;
        Ai  = 32'h0;
        #1;
        chk("cond_zero", {31'h0, cond}, 32'h1);
        step();
        NPCi = 32'h100;
        Immi = 32'h3;
        step();
        chk("br_bo",  Bo, 32'hC);
        chk("br_alu", ALUo, 32'h10C);
        Ai = 32'h7;
        #1;
        chk("cond_nz", {31'h0, cond}, 32'h0);

        // Logic / compare ops
        IRi = 32'h00221824;
        Ai  = 32'hF0F0F0F0;
        Bi  = 32'h0FF00FF0;
        step();
        step();
        chk("and_alu", ALUo, 32'h00F000F0);
        chk("and_bo",  Bo, 32'h0FF00FF0);
        IRi = 32'h00221827;
        step();
        chk("nor_alu", ALUo, 32'h000F000F);
        IRi = 32'h0022182A;
        step();
        chk("slt_alu", ALUo, 32'h1);
        chk("slt_zf",  {31'h0, ZFo}, 32'h0);
        IRi = 32'h0022182B;
        step();
        chk("sltu_alu", ALUo, 32'h0);
        chk("sltu_zf",  {31'h0, ZFo}, 32'h1);

        // SUB to zero, then SUB overflow
        IRi = 32'h00221822;
        Ai  = 32'h12345678;
        Bi  = 32'h12345678;
        step();
        chk("sub_alu", ALUo, 32'h0);
        chk("sub_zf",  {31'h0, ZFo}, 32'h1);
        chk("sub_of",  {31'h0, OFo}, 32'h0);
        Ai = 32'h80000000;
        Bi = 32'h00000001;
        step();
        chk("subov_alu", ALUo, 32'h7FFFFFFF);
        chk("subov_of",  {31'h0, OFo}, 32'h1);

        // Asynchronous reset between edges
        #2;
        rst = 1'b0;
        #1;
        chk("arst_iro",  IRo, 32'h0);
        chk("arst_bo",   Bo, 32'h0);
        chk("arst_aluo", ALUo, 32'h0);
        chk("arst_zf",   {31'h0, ZFo}, 32'h1);
        chk("arst_of",   {31'h0, OFo}, 32'h0);
        chk("arst_cond", {31'h0, cond}, 32'h0);
        rst = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
